spi_frame_serializer: RTL

- Downstream stage of the serializer trigger/reset sequencer in the SPI path.
- Consumes the sequencer's single-cycle clear pulse and start pulse.
- On start, latches a parallel word and shifts it out MSB-first as an SPI mode-0 frame (sclk idle low, data changes on falling edge, sampled on rising edge) with chip-select framing.
- Reports busy and a one-cycle done pulse back to the control logic.

---
 rtl/spi_frame_serializer.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/spi_frame_serializer.sv
// SPI mode-0 frame serializer.
// A start pulse latches a parallel word. The word is shifted out MSB-first
// inside a chip-select window, then a one-cycle done pulse is raised.
// A synchronous clear pulse aborts any frame in flight.
module spi_frame_serializer #(
  parameter int DATA_W   = 32,
  parameter int HALF_DIV = 2,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ser_reset,
  input  logic              ser_trigger,
  input  logic [DATA_W-1:0] data_in,
  output logic              sclk,
  output logic              sdo,
  output logic              cs_n,
  output logic              busy,
  output logic              done
);

  localparam int BIT_W  = $clog2(DATA_W + 1);
  localparam int DIV_W  = $clog2(HALF_DIV + 1);
  localparam int PH_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int PH_W   = $clog2(PH_MAX + 1);

  localparam logic [BIT_W-1:0] BIT_LAST   = BIT_W'(DATA_W);
  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(HALF_DIV - 1);
  localparam logic [PH_W-1:0]  SETUP_LAST = PH_W'(CS_SETUP - 1);
  localparam logic [PH_W-1:0]  HOLD_LAST  = PH_W'(CS_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD
  } state_e;

  state_e            state_q,   state_d;
  logic [DATA_W-1:0] shreg_q,   shreg_d;
  logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [DIV_W-1:0]  div_cnt_q, div_cnt_d;
  logic [PH_W-1:0]   ph_cnt_q,  ph_cnt_d;
  logic              sclk_q,    sclk_d;
  logic              sdo_q,     sdo_d;
  logic              cs_n_q,    cs_n_d;
  logic              busy_q,    busy_d;
  logic              done_q,    done_d;

  // Next-state and registered-output logic; the clear pulse overrides everything.
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    div_cnt_d = div_cnt_q;
    ph_cnt_d  = ph_cnt_q;
    sclk_d    = sclk_q;
    sdo_d     = sdo_q;
    cs_n_d    = cs_n_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (ser_trigger) begin
          state_d   = SETUP;
          shreg_d   = data_in;
          sdo_d     = data_in[DATA_W-1];
          cs_n_d    = 1'b0;
          busy_d    = 1'b1;
          sclk_d    = 1'b0;
          bit_cnt_d = '0;
          div_cnt_d = '0;
          ph_cnt_d  = '0;
        end
      end

      SETUP: begin
        if (ph_cnt_q == SETUP_LAST) begin
          state_d   = SHIFT;
          ph_cnt_d  = '0;
          div_cnt_d = '0;
        end else begin
          ph_cnt_d = ph_cnt_q + PH_W'(1);
        end
      end

      SHIFT: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          sclk_d    = ~sclk_q;
          if (!sclk_q) begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end else if (bit_cnt_q < BIT_LAST) begin
            shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
            sdo_d   = shreg_q[DATA_W-2];
          end else begin
            sdo_d    = 1'b0;
            state_d  = HOLD;
            ph_cnt_d = '0;
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end
      end

      HOLD: begin
        if (ph_cnt_q == HOLD_LAST) begin
          state_d  = IDLE;
          ph_cnt_d = '0;
          cs_n_d   = 1'b1;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end else begin
          ph_cnt_d = ph_cnt_q + PH_W'(1);
        end
      end

      default: state_d = IDLE;
    endcase

    if (ser_reset) begin
      state_d   = IDLE;
      shreg_d   = '0;
      bit_cnt_d = '0;
      div_cnt_d = '0;
      ph_cnt_d  = '0;
      sclk_d    = 1'b0;
      sdo_d     = 1'b0;
      cs_n_d    = 1'b1;
      busy_d    = 1'b0;
      done_d    = 1'b0;
    end
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      div_cnt_q <= '0;
      ph_cnt_q  <= '0;
      sclk_q    <= 1'b0;
      sdo_q     <= 1'b0;
      cs_n_q    <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      div_cnt_q <= div_cnt_d;
      ph_cnt_q  <= ph_cnt_d;
      sclk_q    <= sclk_d;
      sdo_q     <= sdo_d;
      cs_n_q    <= cs_n_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign sclk = sclk_q;
  assign sdo  = sdo_q;
  assign cs_n = cs_n_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
